fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BUBBLE_WORD, 32'hFFFF_FFFF, word returned by instruction memory when its enable is low; never a valid instruction.
REQ-003 Clk  in  1  single clock; all state updates on posedge Clk.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  downstream not ready; the presented instruction is not consumed this cycle.
REQ-006 branch_taken  in  1  single-cycle redirect request from downstream.
REQ-007 branch_target  in  32  redirect byte address, valid when branch_taken=1.
REQ-008 instruction_memory_en  out  1  fetch request to instruction memory.
REQ-009 instruction_memory_a  out  32  byte address of the requested word.
REQ-010 instruction_memory_v  in  32  fetched word, returned on the posedge after the request (1-cycle registered read).
REQ-011 instr_out  out  32  instruction presented downstream.
REQ-012 instr_pc  out  32  byte address of instr_out.
REQ-013 instr_valid  out  1  instr_out/instr_pc are valid this cycle.
REQ-014 fetch_count  out  32  count of instructions consumed downstream.

Function
REQ-015 State machine: RUN (hold buffer empty) and HELD (hold buffer full); reset enters RUN.
REQ-016 Internal: pc (next address), resp_valid/resp_pc (word issued last cycle arrives this cycle), hold_word/hold_pc.
REQ-017 In RUN, instruction_memory_en = ~Reset & ~stall, or 1 when branch_taken; instruction_memory_a = pc, or {branch_target[31:2],2'b00} when branch_taken.
REQ-018 On an enabled request, pc <= instruction_memory_a + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-019 In RUN, instr_out = instruction_memory_v, instr_pc = resp_pc, instr_valid = resp_valid & (instruction_memory_v != BUBBLE_WORD).
REQ-020 In RUN, stall=1 with instr_valid=1: capture word/pc into hold buffer, go to HELD; at most one word is ever in flight, so one entry suffices.
REQ-021 In HELD, instr_out/instr_pc from hold buffer, instr_valid=1, instruction_memory_en=0; when stall=0, the held word is consumed, and the fetch at pc issues the same cycle, returning to RUN.
REQ-022 A word is consumed when instr_valid=1, stall=0, branch_taken=0; fetch_count increments by 1 then, wrapping at 2^32.
REQ-023 branch_taken has priority over stall and HELD: instr_valid forced 0 that cycle, hold buffer cleared, state RUN, target request issued that cycle; the word returned next cycle is the target word (redirect latency 1 cycle).
REQ-024 branch_target[1:0] is ignored (address aligned down).
REQ-025 A returned BUBBLE_WORD is dropped, never held, never counted.

Reset
REQ-026 While Reset=1: instruction_memory_en=0, instruction_memory_a=RESET_PC, instr_valid=0, instr_out=0, instr_pc=RESET_PC, fetch_count=0, state RUN, hold empty, resp_valid=0, pc=RESET_PC.
REQ-027 First request (en=1, a=RESET_PC) in the first cycle with Reset=0; any word arriving in that cycle from a pre-reset request is discarded.

Structure
REQ-028 Shared package scc_pkg holds RESET_PC default, BUBBLE_WORD, WORD_BYTES=4 and the fetch state enum.
REQ-029 One sub-module, fetch_hold_buf: single-entry word+pc register with load/clear/full.

Verification
REQ-030 Reset release, stall=0, memory loaded 0x0..0x0C -> addresses 0,4,8,C on consecutive cycles; instr_valid from cycle 2; instr_pc 0,4,8 in order.
REQ-031 stall=1 for 3 cycles while instr_pc=4 -> instr_out/instr_pc stable at 4, en=0 for 3 cycles, next consumed pc=8; fetch_count unchanged during stall.
REQ-032 branch_taken with target 0x100 while HELD at pc=8 -> instr_valid=0 that cycle, a=0x100, next instr_pc=0x100; pc 8 never counted.
REQ-033 branch_target 0x203 -> a=0x200, following request 0x204.
REQ-034 pc=32'hFFFF_FFFC, stall=0 -> next request address 0x0.
REQ-035 Reset asserted mid-stream with word in HELD -> instr_valid=0, fetch_count=0; after release first request to RESET_PC, stale word never presented.

Source files
------------

// File: rtl/scc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scc_pkg
// Purpose  : Shared constants and types for the instruction fetch slice.
// Revision : 1.0  initial release
// ============================================================================
package scc_pkg;

    // Default first fetch address after reset
    localparam logic [31:0] c_RESET_PC    = 32'h0000_0000;
    // Word the instruction memory drives when not enabled; never an instruction
    localparam logic [31:0] c_BUBBLE_WORD = 32'hFFFF_FFFF;
    // Byte stride between consecutive instruction words
    localparam logic [31:0] c_WORD_BYTES  = 32'd4;

    // RUN: hold buffer empty, HELD: hold buffer occupied
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HELD = 1'b1
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_hold_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_hold_buf
// Purpose  : Single-entry word+pc register that parks a fetched instruction
//            while downstream is stalled. Clear wins over load.
// Revision : 1.0  initial release
// ============================================================================
module fetch_hold_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_word,
    input  logic [31:0] i_pc,
    output logic [31:0] o_word,
    output logic [31:0] o_pc,
    output logic        o_full
);

    logic [31:0] r_word;
    logic [31:0] r_pc;
    logic        r_full;

    // Capture or drop the single parked entry
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_word <= 32'h0;
            r_pc   <= 32'h0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_word <= i_word;
            r_pc   <= i_pc;
            r_full <= 1'b1;
        end
    end

    assign o_word = r_word;
    assign o_pc   = r_pc;
    assign o_full = r_full;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch front end for a 1-cycle registered instruction
//            memory. Issues sequential fetches, honours stall via a one-entry
//            hold buffer, redirects on branch_taken, drops bubble words and
//            counts instructions consumed downstream.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit
    import scc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = c_RESET_PC,
    parameter logic [31:0] BUBBLE_WORD = c_BUBBLE_WORD
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        instruction_memory_en,
    output logic [31:0] instruction_memory_a,
    input  logic [31:0] instruction_memory_v,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic [31:0] fetch_count
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic         r_resp_valid;
    logic [31:0]  r_resp_pc;
    logic [31:0]  r_count;

    logic         w_fetch_en;
    logic [31:0]  w_fetch_a;
    logic [31:0]  w_out;
    logic [31:0]  w_out_pc;
    logic         w_valid;
    logic         w_consume;
    logic         w_hold_load;
    logic         w_hold_clear;
    logic [31:0]  w_hold_word;
    logic [31:0]  w_hold_pc;
    logic         w_hold_full;
    logic         w_unused_tgt_lsbs;

    // Byte offset of the redirect target is irrelevant: fetches are word aligned
    assign w_unused_tgt_lsbs = ^branch_target[1:0];

    // Fetch request: a redirect always fetches; otherwise fetch whenever downstream
    // can take a word. In HELD with stall low the held word leaves this cycle, so
    // the next sequential fetch can go out alongside it.
    always_comb begin
        w_fetch_en = 1'b0;
        w_fetch_a  = RESET_PC;
        if (!Reset) begin
            w_fetch_en = branch_taken | ~stall;
            w_fetch_a  = branch_taken ? {branch_target[31:2], 2'b00} : r_pc;
        end
    end

    // Presented instruction: hold buffer first, else the word arriving now
    always_comb begin
        w_out    = instruction_memory_v;
        w_out_pc = r_resp_pc;
        w_valid  = r_resp_valid & (instruction_memory_v != BUBBLE_WORD);
        if (w_hold_full) begin
            w_out    = w_hold_word;
            w_out_pc = w_hold_pc;
            w_valid  = 1'b1;
        end
        if (branch_taken) begin
            w_valid = 1'b0;
        end
        if (Reset) begin
            w_out    = 32'h0;
            w_out_pc = RESET_PC;
            w_valid  = 1'b0;
        end
    end

    assign w_consume    = w_valid & ~stall;
    assign w_hold_load  = ~Reset & ~branch_taken & (r_state == ST_RUN) & w_valid & stall;
    assign w_hold_clear = Reset | branch_taken | ((r_state == ST_HELD) & ~stall);

    fetch_hold_buf u_hold (
        .clk     (Clk),
        .rst     (Reset),
        .i_load  (w_hold_load),
        .i_clear (w_hold_clear),
        .i_word  (w_out),
        .i_pc    (w_out_pc),
        .o_word  (w_hold_word),
        .o_pc    (w_hold_pc),
        .o_full  (w_hold_full)
    );

    // RUN/HELD sequencing; a redirect always lands in RUN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_RUN;
        end else if (branch_taken) begin
            r_state <= ST_RUN;
        end else if (w_hold_load) begin
            r_state <= ST_HELD;
        end else if ((r_state == ST_HELD) && !stall) begin
            r_state <= ST_RUN;
        end
    end

    // Next fetch address and record of the request now in flight
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc         <= RESET_PC;
            r_resp_valid <= 1'b0;
            r_resp_pc    <= RESET_PC;
        end else begin
            if (w_fetch_en) begin
                r_pc <= w_fetch_a + c_WORD_BYTES;
            end
            r_resp_valid <= w_fetch_en;
            r_resp_pc    <= w_fetch_a;
        end
    end

    // Count of instructions accepted downstream (wraps naturally)
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_count <= 32'h0;
        end else if (w_consume) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign instruction_memory_en = w_fetch_en;
    assign instruction_memory_a  = w_fetch_a;
    assign instr_out             = w_out;
    assign instr_pc              = w_out_pc;
    assign instr_valid           = w_valid;
    assign fetch_count           = Reset ? 32'h0 : r_count;

endmodule
`default_nettype wire
